// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: register-file read index, EX/MEM operand forwarding,
// load-use hazard detection with a one-cycle stall, and the ID/EX register.
module id_ex_stage #(
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [4:0]        id_dst,
  input  logic              id_is_load,
  input  logic              id_use_imm,
  input  logic [31:0]       id_imm,
  input  logic [31:0]       id_pc,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  output logic [9:0]        rs_rt,
  input  logic [31:0]       val_rs,
  input  logic [31:0]       val_rt,
  input  logic [31:0]       ex_alu_result,
  input  logic [4:0]        mem_rd,
  input  logic [31:0]       mem_result,
  output logic              stall_out,
  output logic              ex_valid,
  output logic [31:0]       ex_op_a,
  output logic [31:0]       ex_op_b,
  output logic [31:0]       ex_store_data,
  output logic [4:0]        ex_dst,
  output logic              ex_is_load,
  output logic [31:0]       ex_pc,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  stall_count
);

  logic [4:0]  ex_dst_eff;
  logic        ex_hit_a;
  logic        ex_hit_b;
  logic        mem_hit_a;
  logic        mem_hit_b;
  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic        hz;
  logic        bubble;

  assign rs_rt = {id_rs, id_rt};

  // A bubble in EX has no destination, so it can never be a forwarding source.
  assign ex_dst_eff = ex_valid ? ex_dst : 5'd0;

  // Load data is not ready in EX; a matching load is handled by the stall instead.
  assign ex_hit_a  = (ex_dst_eff != 5'd0) && (id_rs == ex_dst_eff) && !ex_is_load;
  assign ex_hit_b  = (ex_dst_eff != 5'd0) && (id_rt == ex_dst_eff) && !ex_is_load;
  assign mem_hit_a = (mem_rd != 5'd0) && (id_rs == mem_rd);
  assign mem_hit_b = (mem_rd != 5'd0) && (id_rt == mem_rd);

  always_comb begin
    fwd_a = val_rs;
    if (ex_hit_a)
      fwd_a = ex_alu_result;
    else if (mem_hit_a)
      fwd_a = mem_result;
  end

  always_comb begin
    fwd_b = val_rt;
    if (ex_hit_b)
      fwd_b = ex_alu_result;
    else if (mem_hit_b)
      fwd_b = mem_result;
  end

  assign hz = id_valid && ex_valid && ex_is_load && (ex_dst != 5'd0) &&
              ((id_uses_rs && (id_rs == ex_dst)) || (id_uses_rt && (id_rt == ex_dst)));

  // A redirect kills the dependent instruction, so there is nothing to hold.
  assign stall_out = hz && !flush;
  assign bubble    = flush || !id_valid || hz;

  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_valid      <= 1'b0;
      ex_op_a       <= '0;
      ex_op_b       <= '0;
      ex_store_data <= '0;
      ex_dst        <= '0;
      ex_is_load    <= 1'b0;
      ex_pc         <= '0;
      ex_ctrl       <= '0;
    end else if (bubble) begin
      ex_valid   <= 1'b0;
      ex_dst     <= '0;
      ex_is_load <= 1'b0;
      ex_ctrl    <= '0;
    end else begin
      ex_valid      <= 1'b1;
      ex_op_a       <= fwd_a;
      ex_op_b       <= id_use_imm ? id_imm : fwd_b;
      ex_store_data <= fwd_b;
      ex_dst        <= id_dst;
      ex_is_load    <= id_is_load;
      ex_pc         <= id_pc;
      ex_ctrl       <= id_ctrl;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)
      stall_count <= '0;
    else if (stall_out && (stall_count != {CNT_W{1'b1}}))
      stall_count <= stall_count + CNT_W'(1);
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute stage that sits directly downstream of the register file.
- Drives the register file's packed read index, forwards operands from the EX and MEM stages, and detects load-use hazards (stall plus bubble).
- Latches the ID/EX pipeline register that feeds the ALU.
- WB-stage forwarding is not needed: the register file writes on the falling edge and reads combinationally, so a WB write is visible before the next rising edge.

Parameters:
CTRL_W, 8, width of the opaque decoded control bundle carried to EX
CNT_W, 16, width of the saturating load-use stall counter

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_rs  in  5  source register A index
id_rt  in  5  source register B index
id_uses_rs  in  1  instruction reads rs
id_uses_rt  in  1  instruction reads rt
id_dst  in  5  destination register (0 = no write)
id_is_load  in  1  instruction is a load
id_use_imm  in  1  operand B comes from id_imm instead of rt
id_imm  in  32  sign/zero-extended immediate
id_pc  in  32  PC of ID instruction
id_ctrl  in  CTRL_W  decoded control, passed through unchanged
flush  in  1  kill ID instruction (branch/jump redirect)
rs_rt  out  10  register file read index, {id_rs, id_rt}
val_rs  in  32  register file read data A
val_rt  in  32  register file read data B
ex_alu_result  in  32  combinational ALU result of the instruction now in EX
mem_rd  in  5  destination of the instruction in MEM (0 = none)
mem_result  in  32  value the MEM instruction will write (ALU or load data)
stall_out  out  1  hold PC and IF/ID this cycle
ex_valid  out  1  EX stage holds a real instruction
ex_op_a  out  32  operand A
ex_op_b  out  32  operand B (forwarded rt, or immediate)
ex_store_data  out  32  forwarded rt value (always rt, for stores)
ex_dst  out  5  destination register
ex_is_load  out  1  EX instruction is a load
ex_pc  out  32  PC
ex_ctrl  out  CTRL_W  control bundle
stall_count  out  CNT_W  number of load-use stall cycles, saturating

Behaviour:
- Reset (RST high at rising edge): all ex_* outputs go to 0, ex_valid=0, stall_count=0. A reset in mid-operation discards any in-flight instruction. stall_out is combinational and reads 0 while ex_valid=0.
- rs_rt is {id_rs, id_rt}, purely combinational with zero latency.
- Effective EX destination: ex_dst when ex_valid=1, otherwise 0. A destination of 0 never matches anything and never forwards.
- Forwarding for operand A, evaluated combinationally and in priority order:
  - EX match (id_rs == effective EX dst != 0, and ex_is_load=0): use ex_alu_result.
  - Else MEM match (id_rs == mem_rd != 0): use mem_result.
  - Else: use val_rs.
- Operand B follows the identical rule using id_rt and val_rt.
- Load-use hazard: hz = id_valid & ex_valid & ex_is_load & ex_dst != 0 & ((id_uses_rs & id_rs == ex_dst) | (id_uses_rt & id_rt == ex_dst)).
- stall_out = hz & ~flush.
- Next-state on each rising edge, in priority order:
  - RST: clear all registers.
  - Else if flush, ~id_valid, or hz: insert a bubble. ex_valid=0, ex_dst=0, ex_is_load=0, ex_ctrl=0; the data fields may hold any value.
  - Else: latch ex_valid=1, ex_op_a = forwarded A, ex_op_b = id_use_imm ? id_imm : forwarded B, ex_store_data = forwarded B, and the remaining id_* fields into their ex_* counterparts.
- Latency: one cycle from ID to the ex_* outputs.
- A stall lasts exactly one cycle. The load moves to MEM, and on the retry the operand forwards from mem_result.
- stall_count increments by 1 on every edge where stall_out=1 and RST=0. It holds at all-ones.
- Simultaneous events:
  - flush together with hz: flush wins, stall_out=0, bubble inserted.
  - EX and MEM both match: EX wins.
  - id_rs == id_rt: both operands receive the same forwarded value.

Test Plan:
- Reset with RST=1 for 2 cycles and id_valid=1 -> ex_valid=0, ex_dst=0, stall_count=0, stall_out=0.
- Regfile read path: id_rs=7, id_rt=8, val_rs=13, val_rt=8, no matches -> rs_rt=10'b00111_01000; next cycle ex_op_a=13, ex_op_b=8.
- EX and MEM forwarding:
  - EX instruction writes r3 (non-load), ex_alu_result=0x55; MEM writes r3 with mem_result=0x11; ID reads rs=3 -> ex_op_a=0x55.
  - Same setup but with EX dst=0 -> ex_op_a=0x11.
- Load-use:
  - Load to r4 in EX; ID reads rt=4 with id_uses_rt=1 -> stall_out=1 for one cycle, bubble (ex_valid=0), stall_count=1.
  - Next cycle mem_rd=4, mem_result=0xABCD -> ex_op_b=0xABCD.
- Flush precedence: same load-use setup with flush=1 -> stall_out=0, ex_valid=0, stall_count unchanged.
- Saturation and r0: force stall_count to 0xFFFF and stall again -> stays 0xFFFF. EX dst=0 with ID rs=0 and val_rs=0 -> ex_op_a=0, no stall.
